// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, multi-cycle memory between instruction fetch and the MEM stage.
// Optional macro ROUND_ROBIN_EN: alternate the grant on conflicts instead of fixed data-first priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic [1:0]        d_mem_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic       OWN_FETCH   = 1'b0;
    localparam logic       OWN_DATA    = 1'b1;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              m_req_reg, m_req_next;
    logic              m_wr_reg, m_wr_next;
    logic [ADDR_W-1:0] m_addr_reg, m_addr_next;
    logic [DATA_W-1:0] m_wdata_reg, m_wdata_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic              err_reg, err_next;
    logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

    logic       data_req;
    logic       pick_data;
    logic [7:0] cnt_inc;

    // 01 is reserved and behaves like "no access", so only bit 1 marks a data request.
    assign data_req = d_mem_en[1];
    assign cnt_inc  = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;

`ifdef ROUND_ROBIN_EN
    logic last_owner_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_reg <= OWN_FETCH;
        end else if (state_reg == IDLE && (data_req || if_req)) begin
            last_owner_reg <= pick_data;
        end
    end

    assign pick_data = data_req & (~if_req | (last_owner_reg == OWN_FETCH));
`else
    assign pick_data = data_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= OWN_FETCH;
            m_req_reg    <= 1'b0;
            m_wr_reg     <= 1'b0;
            m_addr_reg   <= '0;
            m_wdata_reg  <= '0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            m_req_reg    <= m_req_next;
            m_wr_reg     <= m_wr_next;
            m_addr_reg   <= m_addr_next;
            m_wdata_reg  <= m_wdata_next;
            cnt_reg      <= cnt_next;
            err_reg      <= err_next;
            if_rdata_reg <= if_rdata_next;
            d_rdata_reg  <= d_rdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        m_req_next    = 1'b0;
        m_wr_next     = m_wr_reg;
        m_addr_next   = m_addr_reg;
        m_wdata_next  = m_wdata_reg;
        cnt_next      = cnt_reg;
        err_next      = err_reg;
        if_rdata_next = if_rdata_reg;
        d_rdata_next  = d_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (data_req || if_req) begin
                    state_next = BUSY;
                    owner_next = pick_data;
                    m_req_next = 1'b1;
                    cnt_next   = '0;
                    if (pick_data) begin
                        m_wr_next    = d_mem_en[0];
                        m_addr_next  = d_addr;
                        m_wdata_next = d_wdata;
                    end else begin
                        m_wr_next    = 1'b0;
                        m_addr_next  = if_addr;
                        m_wdata_next = '0;
                    end
                end
            end
            BUSY: begin
                if (m_ack) begin
                    state_next = RESP;
                    if (owner_reg == OWN_FETCH) begin
                        if_rdata_next = m_rdata;
                    end else if (!m_wr_reg) begin
                        d_rdata_next = m_rdata;
                    end
                end else begin
                    cnt_next = cnt_inc;
                    // Forced completion: the waiting requester gets zero data and err latches.
                    if (cnt_inc >= TIMEOUT_CNT) begin
                        state_next = RESP;
                        err_next   = 1'b1;
                        if (owner_reg == OWN_FETCH) begin
                            if_rdata_next = '0;
                        end else if (!m_wr_reg) begin
                            d_rdata_next = '0;
                        end
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign if_done  = (state_reg == RESP) && (owner_reg == OWN_FETCH);
    assign d_done   = (state_reg == RESP) && (owner_reg == OWN_DATA);
    assign if_stall = if_req & ~if_done;
    assign d_stall  = data_req & ~d_done;
    assign m_req    = m_req_reg;
    assign m_wr     = m_wr_reg;
    assign m_addr   = m_addr_reg;
    assign m_wdata  = m_wdata_reg;
    assign err      = err_reg;
    assign if_rdata = if_rdata_reg;
    assign d_rdata  = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration, latency and timeout rules.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int TO     = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;
    logic [1:0]        d_mem_en;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;
    logic              m_req;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_mem_en(d_mem_en), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .d_stall(d_stall), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
    );

    // Inputs change just after the rising edge; outputs are read on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_mem_en = 2'b00; d_addr = '0; d_wdata = '0;
        m_ack = 1'b0; m_rdata = '0;
        tick(); tick();
        sample();
        checks++; if ({m_req, m_wr, if_done, d_done, err, if_stall, d_stall} !== 7'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 0000000", {m_req, m_wr, if_done, d_done, err, if_stall, d_stall}); end
        checks++; if (m_addr !== 16'h0) begin errors++; $display("FAIL reset_m_addr: got %h want 0000", m_addr); end
        checks++; if (m_wdata !== 16'h0) begin errors++; $display("FAIL reset_m_wdata: got %h want 0000", m_wdata); end
        checks++; if ({if_rdata, d_rdata} !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata}); end
        rst = 1'b0;
        $display("test_reset: outputs cleared");
    endtask

    task automatic test_store_fetch();
        tick();
        d_mem_en = 2'b11; d_addr = 16'h0100; d_wdata = 16'h1234; if_req = 1'b1; if_addr = 16'h0200;
        sample();
        checks++; if ({if_stall, d_stall} !== 2'b11) begin errors++; $display("FAIL sf_stalls: got %b want 11", {if_stall, d_stall}); end
        tick();
        sample();
        checks++; if ({m_req, m_wr, m_addr, m_wdata} !== {1'b1, 1'b1, 16'h0100, 16'h1234}) begin
            errors++; $display("FAIL sf_store_issue: got req=%b wr=%b addr=%h wdata=%h want 1 1 0100 1234", m_req, m_wr, m_addr, m_wdata); end
        tick();
        m_ack = 1'b1; m_rdata = 16'h5555;
        sample();
        tick();
        m_ack = 1'b0;
        sample();
        checks++; if ({d_done, m_req, if_stall} !== 3'b101) begin
            errors++; $display("FAIL sf_resp: got done=%b m_req=%b if_stall=%b want 1 0 1", d_done, m_req, if_stall); end
        checks++; if (d_rdata !== 16'h0000) begin errors++; $display("FAIL sf_store_rdata: got %h want 0000", d_rdata); end
        tick();
        d_mem_en = 2'b00;
        sample();
        checks++; if ({m_req, if_stall} !== 2'b01) begin errors++; $display("FAIL sf_idle: got m_req=%b if_stall=%b want 0 1", m_req, if_stall); end
        tick();
        m_ack = m_req; m_rdata = 16'hCAFE;
        sample();
        checks++; if ({m_req, m_wr, m_addr} !== {1'b1, 1'b0, 16'h0200}) begin
            errors++; $display("FAIL sf_fetch_issue: got req=%b wr=%b addr=%h want 1 0 0200", m_req, m_wr, m_addr); end
        tick();
        m_ack = 1'b0;
        sample();
        checks++; if ({if_done, if_stall, if_rdata} !== {1'b1, 1'b0, 16'hCAFE}) begin
            errors++; $display("FAIL sf_fetch_done: got done=%b stall=%b rdata=%h want 1 0 cafe", if_done, if_stall, if_rdata); end
        tick();
        if_req = 1'b0;
        $display("test_store_fetch: store then fetch complete");
    endtask

    task automatic test_load();
        tick();
        d_mem_en = 2'b10; d_addr = 16'h0040;
        sample();
        checks++; if ({m_req, d_stall} !== 2'b01) begin errors++; $display("FAIL load_req_cycle: got m_req=%b d_stall=%b want 0 1", m_req, d_stall); end
        tick();
        sample();
        checks++; if ({m_req, m_wr, m_addr} !== {1'b1, 1'b0, 16'h0040}) begin
            errors++; $display("FAIL load_issue: got req=%b wr=%b addr=%h want 1 0 0040", m_req, m_wr, m_addr); end
        tick();
        sample();
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL load_mreq_once: got %b want 0", m_req); end
        tick();
        m_ack = 1'b1; m_rdata = 16'hBEEF;
        sample();
        checks++; if ({d_done, d_stall} !== 2'b01) begin errors++; $display("FAIL load_ack_cycle: got done=%b stall=%b want 0 1", d_done, d_stall); end
        tick();
        m_ack = 1'b0; m_rdata = 16'h0000;
        sample();
        checks++; if ({d_done, d_stall, d_rdata} !== {1'b1, 1'b0, 16'hBEEF}) begin
            errors++; $display("FAIL load_done: got done=%b stall=%b rdata=%h want 1 0 beef", d_done, d_stall, d_rdata); end
        tick();
        d_mem_en = 2'b00;
        sample();
        checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL load_done_pulse: got %b want 0", d_done); end
        $display("test_load: addr=0040 rdata=%h", d_rdata);
    endtask

    task automatic test_reserved();
        tick();
        d_mem_en = 2'b01;
        for (int i = 0; i < 5; i++) begin
            sample();
            checks++; if ({m_req, d_stall, d_done} !== 3'b000) begin
                errors++; $display("FAIL reserved_%0d: got m_req=%b d_stall=%b d_done=%b want 0 0 0", i, m_req, d_stall, d_done); end
            tick();
        end
        d_mem_en = 2'b00;
        $display("test_reserved: encoding 01 ignored");
    endtask

    task automatic test_contention();
        bit got[4];
        bit exp_owner;
        bit prev_mreq = 1'b0;
        bit stall_dropped = 1'b0;
        int n_done = 0;
        int n_grant = 0;
        int cyc = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0; d_mem_en = 2'b10; d_addr = 16'h0D00; if_req = 1'b1; if_addr = 16'h0F00;
        while (n_done < 4 && cyc < 80) begin
            tick(); cyc++;
            m_ack = prev_mreq; m_rdata = 16'($urandom);
            prev_mreq = m_req;
            if (m_req && n_grant < 4) begin got[n_grant] = (m_addr == 16'h0D00); n_grant++; end
            sample();
            if (!if_stall) stall_dropped = 1'b1;
            if (if_done || d_done) n_done++;
        end
        tick();
        if_req = 1'b0; d_mem_en = 2'b00; m_ack = 1'b0;
        checks++; if (n_done != 4 || n_grant != 4) begin
            errors++; $display("FAIL contention_count: got %0d done %0d grants want 4 4", n_done, n_grant); end
        for (int i = 0; i < n_grant; i++) begin
`ifdef ROUND_ROBIN_EN
            exp_owner = (i % 2 == 0);
`else
            exp_owner = 1'b1;
`endif
            checks++; if (got[i] !== exp_owner) begin
                errors++; $display("FAIL contention_grant%0d: got data=%b want data=%b", i, got[i], exp_owner); end
        end
`ifndef ROUND_ROBIN_EN
        checks++; if (stall_dropped) begin errors++; $display("FAIL contention_if_stall: got dropped want held"); end
`endif
        $display("test_contention: %0d grants", n_grant);
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        int done_at = -1;
        tick();
        if_req = 1'b1; if_addr = 16'h0300;
        for (int i = 0; i < 5 && !seen; i++) begin
            tick();
            seen = m_req;
        end
        sample();
        checks++; if (!seen) begin errors++; $display("FAIL timeout_issue: got no m_req want m_req"); end
        for (int k = 1; k <= TO + 4 && done_at < 0; k++) begin
            tick();
            sample();
            if (k == TO - 1) begin
                checks++; if ({if_done, err} !== 2'b00) begin
                    errors++; $display("FAIL timeout_early: got done=%b err=%b want 0 0", if_done, err); end
            end
            if (if_done) done_at = k;
        end
        checks++; if (done_at != TO) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", done_at, TO); end
        checks++; if ({if_rdata, err, if_stall} !== {16'h0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL timeout_result: got rdata=%h err=%b stall=%b want 0000 1 0", if_rdata, err, if_stall); end
        tick();
        if_req = 1'b0; m_ack = 1'b1; m_rdata = 16'h1111;
        sample();
        tick();
        m_ack = 1'b0;
        sample();
        checks++; if ({m_req, if_done, d_done, if_rdata} !== {3'b000, 16'h0}) begin
            errors++; $display("FAIL stray_ack: got req=%b dones=%b%b rdata=%h want 0 00 0000", m_req, if_done, d_done, if_rdata); end
        tick();
        d_mem_en = 2'b10; d_addr = 16'h0042;
        sample();
        tick();
        m_ack = m_req; m_rdata = 16'h4242;
        sample();
        tick();
        m_ack = 1'b0;
        sample();
        checks++; if ({d_done, d_rdata, err} !== {1'b1, 16'h4242, 1'b1}) begin
            errors++; $display("FAIL err_sticky: got done=%b rdata=%h err=%b want 1 4242 1", d_done, d_rdata, err); end
        tick();
        d_mem_en = 2'b00;
        $display("test_timeout: done after %0d cycles", done_at);
    endtask

    task automatic test_reset_mid_busy();
        tick();
        d_mem_en = 2'b10; d_addr = 16'h0500;
        sample();
        tick();
        sample();
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL rmb_issue: got %b want 1", m_req); end
        tick();
        rst = 1'b1;
        sample();
        tick();
        rst = 1'b0; d_mem_en = 2'b00; m_ack = 1'b1; m_rdata = 16'h9999;
        sample();
        checks++; if ({m_req, m_wr, m_addr, m_wdata, err, d_done, if_done, d_rdata, if_rdata} !== '0) begin
            errors++; $display("FAIL rmb_cleared: got req=%b addr=%h err=%b d_done=%b d_rdata=%h want all 0", m_req, m_addr, err, d_done, d_rdata); end
        tick();
        m_ack = 1'b0;
        sample();
        checks++; if ({d_done, m_req, d_rdata} !== {2'b00, 16'h0}) begin
            errors++; $display("FAIL rmb_late_ack: got done=%b req=%b rdata=%h want 0 0 0000", d_done, m_req, d_rdata); end
        tick();
        if_req = 1'b1; if_addr = 16'h0600;
        sample();
        tick();
        m_ack = m_req; m_rdata = 16'hABCD;
        sample();
        checks++; if ({m_req, m_addr} !== {1'b1, 16'h0600}) begin
            errors++; $display("FAIL rmb_next_issue: got req=%b addr=%h want 1 0600", m_req, m_addr); end
        tick();
        m_ack = 1'b0;
        sample();
        checks++; if ({if_done, if_rdata} !== {1'b1, 16'hABCD}) begin
            errors++; $display("FAIL rmb_next_done: got done=%b rdata=%h want 1 abcd", if_done, if_rdata); end
        tick();
        if_req = 1'b0;
        $display("test_reset_mid_busy: recovered");
    endtask

    task automatic test_random();
        bit busy = 1'b0, t_owner = 1'b0, t_wr = 1'b0, t_to = 1'b0;
        bit f_act = 1'b0, d_act = 1'b0, in_busy, exp_mreq, exp_ifd, exp_dd, exp_err = 1'b0;
        int issue_c = 0, ack_c = 0, done_c = 0, lat, n_txn = 0;
        logic [1:0] d_op = 2'b10;
        logic [15:0] t_addr = '0, t_wdata = '0, t_rdata = '0, exp_if = '0, exp_d = '0;
`ifdef ROUND_ROBIN_EN
        bit last_data = 1'b0;
`endif
        rst = 1'b1; if_req = 1'b0; d_mem_en = 2'b00; m_ack = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            tick();
            if (busy && c == done_c + 1) begin
                busy = 1'b0;
                if (t_owner) d_act = 1'b0; else f_act = 1'b0;
            end
            if (!f_act && $urandom_range(0, 1) == 1) begin f_act = 1'b1; if_addr = 16'($urandom); end
            if (!d_act && $urandom_range(0, 1) == 1) begin
                d_act = 1'b1; d_op = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
                d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            in_busy = busy && c >= issue_c && c < done_c;
            // The owner's address/data lines wander while the memory is busy; they must be ignored.
            if (in_busy) begin
                if (t_owner) begin d_addr = 16'($urandom); d_wdata = 16'($urandom); end
                else if_addr = 16'($urandom);
            end
            if_req = f_act;
            d_mem_en = d_act ? d_op : (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00);
            m_rdata = 16'($urandom);
            if (in_busy) m_ack = !t_to && c == ack_c;
            else m_ack = ($urandom_range(0, 4) == 0);
            if (in_busy && m_ack) t_rdata = m_rdata;
            exp_mreq = busy && c == issue_c;
            exp_ifd = busy && c == done_c && !t_owner;
            exp_dd = busy && c == done_c && t_owner;
            if (busy && c == done_c) begin
                if (t_to) exp_err = 1'b1;
                if (!t_owner) exp_if = t_to ? 16'h0 : t_rdata;
                else if (!t_wr) exp_d = t_to ? 16'h0 : t_rdata;
                n_txn++;
                $display("txn %0d: %s addr=%h wr=%0d timeout=%0d", n_txn, t_owner ? "data " : "fetch", t_addr, t_wr, t_to);
            end
            if (!busy && (f_act || d_act)) begin
`ifdef ROUND_ROBIN_EN
                t_owner = d_act && (!f_act || !last_data);
                last_data = t_owner;
`else
                t_owner = d_act;
`endif
                busy = 1'b1; issue_c = c + 1;
                t_addr = t_owner ? d_addr : if_addr;
                t_wr = t_owner && d_op[0];
                t_wdata = d_wdata;
                lat = $urandom_range(0, TO + 3);
                t_to = (lat >= TO);
                ack_c = issue_c + lat;
                done_c = t_to ? issue_c + TO : ack_c + 1;
            end
            sample();
            checks++; if (m_req !== exp_mreq) begin errors++; $display("FAIL rnd_mreq c=%0d: got %b want %b", c, m_req, exp_mreq); end
            checks++; if ({if_done, d_done} !== {exp_ifd, exp_dd}) begin
                errors++; $display("FAIL rnd_done c=%0d: got %b%b want %b%b", c, if_done, d_done, exp_ifd, exp_dd); end
            checks++; if (if_rdata !== exp_if) begin errors++; $display("FAIL rnd_if_rdata c=%0d: got %h want %h", c, if_rdata, exp_if); end
            checks++; if (d_rdata !== exp_d) begin errors++; $display("FAIL rnd_d_rdata c=%0d: got %h want %h", c, d_rdata, exp_d); end
            checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd_err c=%0d: got %b want %b", c, err, exp_err); end
            checks++; if ({if_stall, d_stall} !== {f_act & ~exp_ifd, d_act & ~exp_dd}) begin
                errors++; $display("FAIL rnd_stall c=%0d: got %b%b want %b%b", c, if_stall, d_stall, f_act & ~exp_ifd, d_act & ~exp_dd); end
            if (busy && c >= issue_c && c <= done_c) begin
                checks++; if ({m_wr, m_addr} !== {t_wr, t_addr}) begin
                    errors++; $display("FAIL rnd_issue c=%0d: got wr=%b addr=%h want %b %h", c, m_wr, m_addr, t_wr, t_addr); end
                if (t_wr) begin
                    checks++; if (m_wdata !== t_wdata) begin
                        errors++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, m_wdata, t_wdata); end
                end
            end
        end
        tick();
        if_req = 1'b0; d_mem_en = 2'b00; m_ack = 1'b0;
        $display("test_random: %0d transactions", n_txn);
    endtask

    initial begin
        test_reset();
        test_store_fetch();
        test_load();
        test_reserved();
        test_contention();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
